fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle execute core.
- Generates sequential PCs and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small in-order queue and delivers {instr_data, instr_pc} to the core over valid/ready.
- Accepts redirects (branch, JAL, JALR) from the core: flushes the queue and discards in-flight responses.

Parameters:
- QUEUE_DEPTH, 4, entries in the instruction queue; power of two, 2 to 8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered imem requests; 1 to 4.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  core requests a PC change this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in order.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  core consumes the head this cycle.
- instr_data  out  32  head instruction word.
- instr_pc  out  32  address of the head instruction.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - fetch_pc=RESET_PC.
  - Queue empty; outstanding=0; drop_cnt=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - Reset mid-transaction abandons all in-flight requests. The bench must not return rvalid for them after release.
- Credit rule: imem_req=1 only when outstanding<MAX_OUTSTANDING and (count+outstanding)<QUEUE_DEPTH, so a response always has a free slot. The queue never overflows.
- First imem_req rises in the first cycle after reset_n deasserts.
- Request handshake:
  - imem_addr=fetch_pc.
  - Once asserted, imem_req and imem_addr hold stable until imem_gnt.
  - On gnt: fetch_pc+=4 (wraps 32'hFFFF_FFFC to 0), outstanding+=1.
  - Back-to-back grants are allowed.
- Response handling:
  - On rvalid with drop_cnt=0: push {imem_rdata, pc of the oldest in-flight request} to the queue tail; outstanding-=1.
  - On rvalid with drop_cnt>0: discard the word; drop_cnt-=1; outstanding-=1.
  - Gnt and rvalid in the same cycle leave outstanding unchanged.
- Output:
  - instr_valid = queue non-empty; instr_data/instr_pc come from the queue head register, with no combinational path from imem_rdata.
  - Latency: rvalid in cycle N makes the entry visible at cycle N+1.
  - Pop when instr_valid and instr_ready. Push and pop in the same cycle are permitted at any occupancy.
  - Outputs hold while instr_valid=1 and instr_ready=0.
- Redirect (registered effect, next cycle):
  - Queue flushed, so instr_valid=0 in cycle N+1.
  - drop_cnt = outstanding after this cycle's gnt/rvalid accounting. A gnt in the redirect cycle is counted as dropped; an rvalid in the redirect cycle is discarded.
  - If imem_req is pending without gnt: the request stays stable until granted and is then dropped (drop_cnt+1). fetch_pc loads redirect_pc only after that grant.
  - Otherwise fetch_pc=redirect_pc in cycle N+1, and a new request may issue in cycle N+1.
  - A pop in the redirect cycle is still honoured.
  - A second redirect while drops are pending accumulates correctly; the last redirect_pc wins.
- The core owns instr_ready; instr_ready with instr_valid=0 has no effect.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output port instr_fault (1 bit).
  - A redirect_pc with bits [1:0]≠0 is not fetched. The next instruction presented has instr_valid=1, instr_fault=1, instr_data=32'h0000_0013 (NOP) and instr_pc=redirect_pc unmasked.
  - Fetching stalls until that entry is consumed or another redirect arrives.
- Undefined: no instr_fault port; redirect_pc[1:0] are silently masked to 0.

Test Plan:
- Reset release, imem gnt every cycle, rvalid 1 cycle after gnt, instr_ready=1 -> imem_addr 0x0,0x4,0x8,...; instr_pc 0x0,0x4,... on consecutive cycles; first instr_valid 3 cycles after reset release.
- instr_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> exactly 4 grants, then imem_req=0; instr_pc=0x0 held; releasing ready drains 0x0,0x4,0x8,0xC in order.
- Redirect to 0x100 with 2 responses outstanding -> both responses discarded; next instr_pc=0x100; no 0x8/0xC entries ever presented.
- Redirect to 0x200 while imem_req pending ungranted at 0x40 -> addr 0x40 held until gnt, its data dropped, next request addr=0x200.
- Gnt stalled 5 cycles with imem_addr=0x20 -> imem_req/imem_addr stable throughout; fetch_pc advances to 0x24 only after gnt.
- FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x102 -> instr_fault=1, instr_pc=0x102, instr_data=0x00000013; no imem request issued until consumed.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, imem req/gnt/rvalid fetch, in-order
// instruction queue toward the execute core, redirect flush with response drop.
// Build option: define FETCH_ALIGN_CHECK_EN to add instr_fault and turn
// misaligned redirect targets into a single faulting NOP entry.
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        instr_fault
`endif
);

    localparam int unsigned QW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW  = 5;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
`endif

    typedef struct packed {
`ifdef FETCH_ALIGN_CHECK_EN
        logic        fault;
`endif
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // State
    logic [31:0]    fetch_pc, fetch_pc_nx;
    logic           req_q, req_nx;
    entry_t         q_mem [QUEUE_DEPTH];
    logic [QW-1:0]  rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
    logic [QCW-1:0] count, count_nx;
    logic [31:0]    inf_pc [MAX_OUTSTANDING];
    logic [OW-1:0]  inf_rd, inf_rd_nx, inf_wr, inf_wr_nx;
    logic [OCW-1:0] outstanding, out_nx, drop_cnt, drop_nx;
    logic           redir_pend, pend_nx;
    logic [31:0]    redir_target, target_nx;
    entry_t         head, head_nx;
    logic           head_valid, head_valid_nx;
`ifdef FETCH_ALIGN_CHECK_EN
    logic           fault_stall, stall_nx;
    logic           misalign;
`else
    logic           unused_lsbs;
`endif

    // Per-cycle events
    logic        gnt_ok, pop, push, we, credit;
    logic [QW-1:0] waddr;
    entry_t      wdata;
    logic [31:0] target;

    assign gnt_ok = req_q & imem_gnt;
    assign pop    = head_valid & instr_ready;
    assign push   = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;
    assign target = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    assign unused_lsbs = ^redirect_pc[1:0];
`endif

    function automatic logic [OW-1:0] inf_inc(input logic [OW-1:0] p);
        return (p == OW'(MAX_OUTSTANDING - 1)) ? '0 : p + OW'(1);
    endfunction

    // Next-state: credit accounting, queue pointers, fetch address, redirect handling
    always_comb begin
        out_nx = outstanding;
        if (gnt_ok && !imem_rvalid)      out_nx = outstanding + OCW'(1);
        else if (!gnt_ok && imem_rvalid) out_nx = outstanding - OCW'(1);

        inf_wr_nx = gnt_ok      ? inf_inc(inf_wr) : inf_wr;
        inf_rd_nx = imem_rvalid ? inf_inc(inf_rd) : inf_rd;

        we         = push;
        waddr      = wr_ptr;
        wdata      = '0;
        wdata.pc   = inf_pc[inf_rd];
        wdata.data = imem_rdata;
        wr_ptr_nx  = push ? wr_ptr + QW'(1) : wr_ptr;
        rd_ptr_nx  = pop  ? rd_ptr + QW'(1) : rd_ptr;
        count_nx   = count + QCW'(push) - QCW'(pop);

        fetch_pc_nx = fetch_pc;
        pend_nx     = redir_pend;
        target_nx   = redir_target;
        drop_nx     = drop_cnt;
        if (imem_rvalid && drop_cnt != '0) drop_nx = drop_cnt - OCW'(1);
        if (gnt_ok) begin
            if (redir_pend) begin
                // the request issued before the redirect is granted now and must be dropped
                drop_nx     = drop_nx + OCW'(1);
                fetch_pc_nx = redir_target;
                pend_nx     = 1'b0;
            end else begin
                fetch_pc_nx = fetch_pc + 32'd4;
            end
        end

`ifdef FETCH_ALIGN_CHECK_EN
        stall_nx = fault_stall;
        if (pop && head.fault) stall_nx = 1'b0;
`endif

        if (redirect_valid) begin
            drop_nx   = out_nx;
            we        = 1'b0;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
            if (req_q && !imem_gnt) begin
                pend_nx   = 1'b1;
                target_nx = target;
            end else begin
                pend_nx     = 1'b0;
                fetch_pc_nx = target;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            stall_nx = misalign;
            if (misalign) begin
                we          = 1'b1;
                waddr       = '0;
                wdata.fault = 1'b1;
                wdata.pc    = redirect_pc;
                wdata.data  = NOP;
                wr_ptr_nx   = QW'(1);
                count_nx    = QCW'(1);
            end
`endif
        end

        // every granted request must find a queue slot when its response returns
        credit = (out_nx < OCW'(MAX_OUTSTANDING)) &&
                 ((SW'(count_nx) + SW'(out_nx)) < SW'(QUEUE_DEPTH));
`ifdef FETCH_ALIGN_CHECK_EN
        req_nx = credit & ~stall_nx;
`else
        req_nx = credit;
`endif
        if (req_q && !imem_gnt) req_nx = 1'b1;

        head_valid_nx = (count_nx != '0);
        head_nx       = head;
        if (head_valid_nx) head_nx = (we && waddr == rd_ptr_nx) ? wdata : q_mem[rd_ptr_nx];
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc     <= RESET_PC;
            req_q        <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            inf_rd       <= '0;
            inf_wr       <= '0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            redir_pend   <= 1'b0;
            redir_target <= '0;
            head         <= '0;
            head_valid   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_stall  <= 1'b0;
`endif
        end else begin
            fetch_pc     <= fetch_pc_nx;
            req_q        <= req_nx;
            rd_ptr       <= rd_ptr_nx;
            wr_ptr       <= wr_ptr_nx;
            count        <= count_nx;
            inf_rd       <= inf_rd_nx;
            inf_wr       <= inf_wr_nx;
            outstanding  <= out_nx;
            drop_cnt     <= drop_nx;
            redir_pend   <= pend_nx;
            redir_target <= target_nx;
            head         <= head_nx;
            head_valid   <= head_valid_nx;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_stall  <= stall_nx;
`endif
        end
    end

    // Queue and in-flight PC storage; contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (we)     q_mem[waddr]   <= wdata;
        if (gnt_ok) inf_pc[inf_wr] <= fetch_pc;
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc;
    assign instr_valid = head_valid;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign instr_fault = head.fault;
`endif

endmodule
